instruction_decode: RTL and testbench

- Pipeline stage directly downstream of instruction fetch.
- Accepts 32-bit RV32I instruction words over a valid/stall handshake and decodes them into operation class, register indices, funct fields and a sign-extended immediate.
- Tracks the PC of each accepted instruction.
- Holds one registered decoded entry for the execute stage. Back-pressures fetch when execute stalls. Discards its entry on a PC override (flush).

---
 rtl/instruction_decode.sv | 198 +++++++++++++++++++
 tb/tb_instruction_decode.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/instruction_decode.sv
// instruction_decode
// -----------------------------------------------------------------------------
// RV32I decode stage directly downstream of instruction fetch. It accepts one
// instruction word per cycle over a valid/stall handshake and decodes it into
// an operation class, register indices, funct fields and a sign-extended
// immediate. It holds the result in one registered entry for execute, and tags
// that entry with the PC of the instruction.
//
// Optional feature: define DECODE_RV32M_EN to decode OP with funct7=0000001
// as MULDIV. Without the macro, that encoding is reported as illegal.
//
// Parameters
//   RESET_PC     PC loaded into the internal PC counter on reset
//
// Ports
//   clk          clock; all state updates on the rising edge
//   reset        synchronous, active-high reset
//   inst_in      instruction word from fetch
//   inst_valid   inst_in is valid this cycle
//   stall_out    to fetch: this stage cannot accept (dec_valid & exec_stall)
//   flush        PC override; discards the held entry and reloads the PC
//   flush_addr   new PC on flush
//   exec_stall   execute cannot accept the held entry
//   dec_valid    decoded entry valid
//   dec_pc       PC of the decoded instruction
//   dec_op       operation class (see OP_* below)
//   dec_rd, dec_rs1, dec_rs2, dec_funct3, dec_alt   raw instruction fields
//   dec_imm      sign-extended immediate (0 for OP/MISC_MEM/ILLEGAL)
//   dec_illegal  instruction is illegal
// -----------------------------------------------------------------------------
module instruction_decode #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] inst_in,
  input  logic        inst_valid,
  output logic        stall_out,
  input  logic        flush,
  input  logic [31:0] flush_addr,
  input  logic        exec_stall,
  output logic        dec_valid,
  output logic [31:0] dec_pc,
  output logic [3:0]  dec_op,
  output logic [4:0]  dec_rd,
  output logic [4:0]  dec_rs1,
  output logic [4:0]  dec_rs2,
  output logic [2:0]  dec_funct3,
  output logic        dec_alt,
  output logic [31:0] dec_imm,
  output logic        dec_illegal
);

  localparam logic [3:0] OP_LUI      = 4'd0;
  localparam logic [3:0] OP_AUIPC    = 4'd1;
  localparam logic [3:0] OP_JAL      = 4'd2;
  localparam logic [3:0] OP_JALR     = 4'd3;
  localparam logic [3:0] OP_BRANCH   = 4'd4;
  localparam logic [3:0] OP_LOAD     = 4'd5;
  localparam logic [3:0] OP_STORE    = 4'd6;
  localparam logic [3:0] OP_OP_IMM   = 4'd7;
  localparam logic [3:0] OP_OP       = 4'd8;
  localparam logic [3:0] OP_MISC_MEM = 4'd9;
  localparam logic [3:0] OP_SYSTEM   = 4'd10;
  localparam logic [3:0] OP_MULDIV   = 4'd11;
  localparam logic [3:0] OP_ILLEGAL  = 4'd15;

  logic [31:0] pc_q;
  logic        accept;

  logic [4:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [3:0]  op_d;
  logic [31:0] imm_d;
  logic        illegal_d;

  // Depends only on registered state and exec_stall, so fetch can feed
  // inst_valid from stall_out without creating a combinational loop.
  assign stall_out = dec_valid & exec_stall;
  assign accept    = inst_valid & ~stall_out & ~flush & ~reset;

  assign opcode = inst_in[6:2];
  assign funct3 = inst_in[14:12];
  assign funct7 = inst_in[31:25];

  assign imm_i = {{20{inst_in[31]}}, inst_in[31:20]};
  assign imm_s = {{20{inst_in[31]}}, inst_in[31:25], inst_in[11:7]};
  assign imm_b = {{19{inst_in[31]}}, inst_in[31], inst_in[7], inst_in[30:25],
                  inst_in[11:8], 1'b0};
  assign imm_u = {inst_in[31:12], 12'b0};
  assign imm_j = {{11{inst_in[31]}}, inst_in[31], inst_in[19:12], inst_in[20],
                  inst_in[30:21], 1'b0};

  always_comb begin
    // NOTE: every output of this block gets a default first so no path can
    // leave it unassigned and infer a latch.
    op_d      = OP_ILLEGAL;
    imm_d     = '0;
    illegal_d = 1'b0;
    case (opcode)
      5'b01101: begin op_d = OP_LUI;    imm_d = imm_u; end
      5'b00101: begin op_d = OP_AUIPC;  imm_d = imm_u; end
      5'b11011: begin op_d = OP_JAL;    imm_d = imm_j; end
      5'b11001: begin
        op_d      = OP_JALR;
        imm_d     = imm_i;
        illegal_d = (funct3 != 3'b000);
      end
      5'b11000: begin
        op_d      = OP_BRANCH;
        imm_d     = imm_b;
        illegal_d = (funct3 == 3'b010) || (funct3 == 3'b011);
      end
      5'b00000: begin
        op_d      = OP_LOAD;
        imm_d     = imm_i;
        illegal_d = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
      end
      5'b01000: begin
        op_d      = OP_STORE;
        imm_d     = imm_s;
        illegal_d = (funct3 > 3'b010);
      end
      5'b00100: begin
        op_d  = OP_OP_IMM;
        imm_d = imm_i;
        // Only the shift forms constrain the upper immediate bits; SRAI is
        // the one place funct7=0100000 is legal.
        if (funct3 == 3'b001)
          illegal_d = (funct7 != 7'b0000000);
        else if (funct3 == 3'b101)
          illegal_d = (funct7 != 7'b0000000) && (funct7 != 7'b0100000);
      end
      5'b01100: begin
        op_d = OP_OP;
        if (funct7 == 7'b0000000)
          illegal_d = 1'b0;
        else if (funct7 == 7'b0100000)
          illegal_d = (funct3 != 3'b000) && (funct3 != 3'b101);
`ifdef DECODE_RV32M_EN
        else if (funct7 == 7'b0000001)
          op_d = OP_MULDIV;
`endif
        else
          illegal_d = 1'b1;
      end
      5'b00011: op_d = OP_MISC_MEM;
      5'b11100: begin op_d = OP_SYSTEM; imm_d = imm_i; end
      default:  illegal_d = 1'b1;
    endcase
    if (inst_in[1:0] != 2'b11)
      illegal_d = 1'b1;
    if (illegal_d) begin
      op_d  = OP_ILLEGAL;
      imm_d = '0;
    end
  end

  // Priority: reset, then flush, then accept, then drain. Flush discards even
  // a stalled entry; a stalled entry with no flush simply holds.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignment so every register
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      pc_q        <= RESET_PC;
      dec_valid   <= 1'b0;
      dec_pc      <= '0;
      dec_op      <= '0;
      dec_rd      <= '0;
      dec_rs1     <= '0;
      dec_rs2     <= '0;
      dec_funct3  <= '0;
      dec_alt     <= 1'b0;
      dec_imm     <= '0;
      dec_illegal <= 1'b0;
    end else if (flush) begin
      pc_q      <= flush_addr;
      dec_valid <= 1'b0;
    end else if (accept) begin
      pc_q        <= pc_q + 32'd4;
      dec_valid   <= 1'b1;
      dec_pc      <= pc_q;
      dec_op      <= op_d;
      dec_rd      <= inst_in[11:7];
      dec_rs1     <= inst_in[19:15];
      dec_rs2     <= inst_in[24:20];
      dec_funct3  <= funct3;
      dec_alt     <= inst_in[30];
      dec_imm     <= imm_d;
      dec_illegal <= illegal_d;
    end else if (dec_valid && !exec_stall) begin
      dec_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_instruction_decode.sv
// Testbench for instruction_decode. Stimulus pushes the hand-computed expected
// entry into a scoreboard queue; a monitor pops and compares each entry the
// first time the DUT presents it.
module tb_instruction_decode;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] inst_in;
  logic        inst_valid;
  logic        stall_out;
  logic        flush;
  logic [31:0] flush_addr;
  logic        exec_stall;
  logic        dec_valid;
  logic [31:0] dec_pc;
  logic [3:0]  dec_op;
  logic [4:0]  dec_rd, dec_rs1, dec_rs2;
  logic [2:0]  dec_funct3;
  logic        dec_alt;
  logic [31:0] dec_imm;
  logic        dec_illegal;

  typedef struct {
    logic [31:0] pc;
    logic [3:0]  op;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic        alt;
    logic [31:0] imm;
    logic        ill;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] exp_pc;
  logic        prev_valid = 1'b0;
  logic        prev_stall = 1'b0;

  localparam logic [31:0] NOP = 32'h0000_0013;

  instruction_decode #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .reset(reset), .inst_in(inst_in), .inst_valid(inst_valid),
    .stall_out(stall_out), .flush(flush), .flush_addr(flush_addr),
    .exec_stall(exec_stall), .dec_valid(dec_valid), .dec_pc(dec_pc),
    .dec_op(dec_op), .dec_rd(dec_rd), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
    .dec_funct3(dec_funct3), .dec_alt(dec_alt), .dec_imm(dec_imm),
    .dec_illegal(dec_illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Monitor: an entry is new when the previous cycle had no entry or the
  // previous entry was handed to execute.
  always @(negedge clk) begin
    if (dec_valid === 1'b1 && (!prev_valid || !prev_stall)) begin
      if (sb.size() == 0) begin
        check("unexpected_entry_pc", dec_pc, 32'hxxxx_xxxx);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("dec_pc", dec_pc, e.pc);
        check("dec_op", {28'd0, dec_op}, {28'd0, e.op});
        check("dec_rd", {27'd0, dec_rd}, {27'd0, e.rd});
        check("dec_rs1", {27'd0, dec_rs1}, {27'd0, e.rs1});
        check("dec_rs2", {27'd0, dec_rs2}, {27'd0, e.rs2});
        check("dec_funct3", {29'd0, dec_funct3}, {29'd0, e.f3});
        check("dec_alt", {31'd0, dec_alt}, {31'd0, e.alt});
        check("dec_imm", dec_imm, e.imm);
        check("dec_illegal", {31'd0, dec_illegal}, {31'd0, e.ill});
      end
    end
    prev_valid = dec_valid;
    prev_stall = exec_stall;
  end

  // Present one instruction for one cycle, expecting it to be accepted.
  task automatic send(input logic [31:0] inst, input logic [3:0] op,
                      input logic [31:0] imm, input logic ill);
    exp_t e;
    e.pc = exp_pc; e.op = op; e.imm = imm; e.ill = ill;
    e.rd = inst[11:7]; e.rs1 = inst[19:15]; e.rs2 = inst[24:20];
    e.f3 = inst[14:12]; e.alt = inst[30];
    sb.push_back(e);
    exp_pc = exp_pc + 32'd4;
    inst_in = inst;
    inst_valid = 1'b1;
    @(posedge clk); #1;
    inst_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_pc = 32'h0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; inst_in = '0; inst_valid = 1'b0; flush = 1'b0;
    flush_addr = '0; exec_stall = 1'b0; exp_pc = 32'h0;
    @(posedge clk); #1;
    @(negedge clk);
    check("reset_dec_valid", {31'd0, dec_valid}, 32'd0);
    check("reset_dec_pc", dec_pc, 32'd0);
    check("reset_dec_op", {28'd0, dec_op}, 32'd0);
    check("reset_stall_out", {31'd0, stall_out}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // addi x1,x0,5
    send(32'h0050_0093, 4'd7, 32'd5, 1'b0);
    @(posedge clk); #1;

    // Back-to-back NOPs from reset: PCs 0,4,8,12, no stall.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      send(NOP, 4'd7, 32'd0, 1'b0);
      check("b2b_stall_out", {31'd0, stall_out}, 32'd0);
    end
    @(posedge clk); #1;

    // Stall for 3 cycles with a pending instruction; outputs frozen.
    do_reset();
    send(NOP, 4'd7, 32'd0, 1'b0);
    exec_stall = 1'b1; inst_in = 32'h0010_0093; inst_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_stall_out", {31'd0, stall_out}, 32'd1);
      check("stall_dec_valid", {31'd0, dec_valid}, 32'd1);
      check("stall_dec_pc", dec_pc, 32'd0);
      check("stall_dec_rd", {27'd0, dec_rd}, 32'd0);
      @(posedge clk); #1;
    end
    exec_stall = 1'b0;
    send(32'h0010_0093, 4'd7, 32'd1, 1'b0);
    @(posedge clk); #1;

    // Flush while stalled with inst_valid high.
    do_reset();
    send(NOP, 4'd7, 32'd0, 1'b0);
    exec_stall = 1'b1; flush = 1'b1; flush_addr = 32'h0000_0100;
    inst_in = 32'h0050_0093; inst_valid = 1'b1;
    @(negedge clk);
    check("flush_stall_out", {31'd0, stall_out}, 32'd1);
    @(posedge clk); #1;
    flush = 1'b0; exec_stall = 1'b0; inst_valid = 1'b0;
    exp_pc = 32'h0000_0100;
    @(negedge clk);
    check("flush_dec_valid", {31'd0, dec_valid}, 32'd0);
    @(posedge clk); #1;

    send(32'hFE00_0EE3, 4'd4, 32'hFFFF_FFFC, 1'b0); // beq x0,x0,-4
    send(32'h0000_0000, 4'd15, 32'd0, 1'b1);        // all-zero word
`ifdef DECODE_RV32M_EN
    send(32'h0220_80B3, 4'd11, 32'd0, 1'b0);        // mul x1,x1,x2
`else
    send(32'h0220_80B3, 4'd15, 32'd0, 1'b1);
`endif
    send(32'h1234_50B7, 4'd0, 32'h1234_5000, 1'b0); // lui x1,0x12345
    send(32'h4000_0033, 4'd8, 32'd0, 1'b0);         // sub x0,x0,x0
    send(32'h4010_5093, 4'd7, 32'h0000_0401, 1'b0); // srai x1,x0,1
    send(32'h4010_1093, 4'd15, 32'd0, 1'b1);        // slli with funct7=0100000
    send(32'h0080_006F, 4'd2, 32'd8, 1'b0);         // jal x0,8
    send(32'h0011_2223, 4'd6, 32'd4, 1'b0);         // sw x1,4(x2)
    send(32'h0000_3003, 4'd15, 32'd0, 1'b1);        // load funct3=011
    send(32'h0050_0092, 4'd15, 32'd0, 1'b1);        // inst[1:0]=10
    @(posedge clk); #1;

    // PC wraps from FFFF_FFFC to 0.
    flush = 1'b1; flush_addr = 32'hFFFF_FFFC;
    @(posedge clk); #1;
    flush = 1'b0; exp_pc = 32'hFFFF_FFFC;
    send(NOP, 4'd7, 32'd0, 1'b0);
    send(NOP, 4'd7, 32'd0, 1'b0);
    @(posedge clk); #1;

    // Reset mid-stall discards the entry and wins over a concurrent flush.
    send(NOP, 4'd7, 32'd0, 1'b0);
    exec_stall = 1'b1;
    @(posedge clk); #1;
    reset = 1'b1; flush = 1'b1; flush_addr = 32'h0000_0200;
    @(posedge clk); #1;
    reset = 1'b0; flush = 1'b0; exec_stall = 1'b0; exp_pc = 32'h0;
    @(negedge clk);
    check("rst_stall_dec_valid", {31'd0, dec_valid}, 32'd0);
    check("rst_stall_dec_pc", dec_pc, 32'd0);
    check("rst_stall_dec_imm", dec_imm, 32'd0);
    @(posedge clk); #1;
    send(NOP, 4'd7, 32'd0, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_empty", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
